// File: rtl/matmul_sequencer_if.sv
// Bundle of keypad, multiplier and display signals around the 2x2 matmul sequencer.
// master: the environment (keypad controller, shared multiplier, display path).
// slave:  the sequencer itself.
interface matmul_sequencer_if;
    logic        read_input;
    logic [3:0]  keypad_input;
    logic        equal_input;
    logic        key_read;
    logic        mul_start;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic        mul_done;
    logic [7:0]  mul_product;
    logic [15:0] display_output;
    logic [1:0]  elem_index;
    logic [2:0]  state_out;
    logic        complete;

    modport master (
        output read_input, keypad_input, equal_input, mul_done, mul_product,
        input  key_read, mul_start, mul_a, mul_b, display_output, elem_index,
               state_out, complete
    );

    modport slave (
        input  read_input, keypad_input, equal_input, mul_done, mul_product,
        output key_read, mul_start, mul_a, mul_b, display_output, elem_index,
               state_out, complete
    );
endinterface

// File: rtl/matmul_sequencer.sv
// 2x2 matrix multiply sequencer: collects A and B digits from the keypad,
// drives a shared external multiplier for the eight partial products, then
// shows C one element at a time.
//
// Key handshake: a key event is any cycle with read_input=1 while key_read=0.
// The event is consumed on that clock edge (operand store / state change) and
// key_read is raised for exactly the following cycle as the acknowledge; the
// keypad holds read_input until it sees key_read.
module matmul_sequencer (
    input  logic               clk,
    input  logic               RST,
    matmul_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        LOAD_A   = 3'd0,
        LOAD_B   = 3'd1,
        WAIT_EQ  = 3'd2,
        ISSUE    = 3'd3,
        WAIT_MUL = 3'd4,
        SHOW     = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        key_read_q;
    logic [3:0]  a_reg [4];     // row-major A00, A01, A10, A11
    logic [3:0]  b_reg [4];     // row-major B00, B01, B10, B11
    logic [8:0]  c_reg [4];     // row-major C00, C01, C10, C11
    logic [1:0]  cnt;           // digits taken in the current matrix
    logic [1:0]  ij;            // {i, j} of the C element being built
    logic        k;             // inner-product term index
    logic [8:0]  acc;
    logic [3:0]  last_digit;
    logic [1:0]  elem_idx;

    logic        key_ev;
    logic        is_eq;
    logic        is_digit;
    logic [8:0]  acc_sum;

    assign key_ev   = bus.read_input & ~key_read_q;
    assign is_eq    = key_ev & bus.equal_input;
    assign is_digit = key_ev & ~bus.equal_input & (bus.keypad_input <= 4'd9);
    assign acc_sum  = acc + {1'b0, bus.mul_product};

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= LOAD_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            LOAD_A:   if (is_digit && cnt == 2'd3) state_next = LOAD_B;
            LOAD_B:   if (is_digit && cnt == 2'd3) state_next = WAIT_EQ;
            WAIT_EQ:  if (is_eq) state_next = ISSUE;
            ISSUE:    state_next = WAIT_MUL;
            WAIT_MUL: begin
                if (bus.mul_done) begin
                    state_next = (k && ij == 2'd3) ? SHOW : ISSUE;
                end
            end
            SHOW:     if (is_digit) state_next = LOAD_A;
            default:  state_next = LOAD_A;
        endcase
    end

    // Key acknowledge: every key event is acknowledged one cycle later, whatever the state
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            key_read_q <= 1'b0;
        end else begin
            key_read_q <= key_ev;
        end
    end

    // Operand, accumulator and result registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int n = 0; n < 4; n++) begin
                a_reg[n] <= '0;
                b_reg[n] <= '0;
                c_reg[n] <= '0;
            end
            cnt        <= '0;
            ij         <= '0;
            k          <= 1'b0;
            acc        <= '0;
            last_digit <= '0;
            elem_idx   <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (is_digit) begin
                        a_reg[cnt] <= bus.keypad_input;
                        last_digit <= bus.keypad_input;
                        cnt        <= cnt + 2'd1;   // wraps to 0 for B entry
                    end
                end
                LOAD_B: begin
                    if (is_digit) begin
                        b_reg[cnt] <= bus.keypad_input;
                        last_digit <= bus.keypad_input;
                        cnt        <= cnt + 2'd1;
                    end
                end
                WAIT_EQ: begin
                    if (is_eq) begin
                        ij  <= '0;
                        k   <= 1'b0;
                        acc <= '0;
                    end
                end
                WAIT_MUL: begin
                    if (bus.mul_done) begin
                        if (!k) begin
                            acc <= acc_sum;
                            k   <= 1'b1;
                        end else begin
                            c_reg[ij] <= acc_sum;
                            acc       <= '0;
                            k         <= 1'b0;
                            ij        <= ij + 2'd1;
                            if (ij == 2'd3) elem_idx <= '0;
                        end
                    end
                end
                SHOW: begin
                    if (is_eq) begin
                        elem_idx <= elem_idx + 2'd1;
                    end else if (is_digit) begin
                        // A digit here opens a new problem; it becomes A00.
                        for (int n = 0; n < 4; n++) begin
                            a_reg[n] <= '0;
                            b_reg[n] <= '0;
                            c_reg[n] <= '0;
                        end
                        a_reg[0]   <= bus.keypad_input;
                        last_digit <= bus.keypad_input;
                        cnt        <= 2'd1;
                        elem_idx   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Multiplier operands come straight from the operand registers; i, j, k
    // do not move between ISSUE and mul_done, so they stay stable for the multiply.
    assign bus.mul_start      = (state == ISSUE);
    assign bus.mul_a          = a_reg[{ij[1], k}];
    assign bus.mul_b          = b_reg[{k, ij[0]}];
    assign bus.key_read       = key_read_q;
    assign bus.complete       = (state == SHOW);
    assign bus.elem_index     = elem_idx;
    assign bus.state_out      = state;
    assign bus.display_output = (state == SHOW) ? {7'b0, c_reg[elem_idx]}
                                                : {12'b0, last_digit};

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: keypad driver tasks, a behavioural multiplier
// with programmable latency, and a scoreboard that compares each displayed
// C element against hand-computed values.
module tb_matmul_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    matmul_sequencer_if bus ();

    matmul_sequencer dut (
        .clk (clk),
        .RST (rst),
        .bus (bus)
    );

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          lat       = 1;
    int          start_cnt = 0;
    logic [17:0] exp_q [$];     // {elem_index, display_output}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One key press following the read_input/key_read handshake
    task automatic press(input logic [3:0] code, input logic eq);
        @(posedge clk); #1;
        bus.read_input   = 1'b1;
        bus.keypad_input = code;
        bus.equal_input  = eq;
        @(posedge clk); #1;
        check("key_ack", {31'b0, bus.key_read}, 1);
        bus.read_input  = 1'b0;
        bus.equal_input = 1'b0;
    endtask

    task automatic press_digits(input logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7);
        press(d0, 0); press(d1, 0); press(d2, 0); press(d3, 0);
        press(d4, 0); press(d5, 0); press(d6, 0); press(d7, 0);
    endtask

    // Counts cycles from the "=" acknowledge edge until complete rises
    task automatic wait_complete(input int exp_cycles);
        int n = 0;
        while (!bus.complete && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.complete) check("complete_timeout", 0, 1);
        else               check("compute_latency", n, exp_cycles);
    endtask

    // "=" in SHOW; the scoreboard expects the next element to appear
    task automatic show_next(input logic [1:0] idx, input logic [8:0] val);
        exp_q.push_back({idx, 7'b0, val});
        press(4'd15, 1);
    endtask

    // Behavioural shared multiplier with latency lat
    initial begin
        logic [3:0] a_cap, b_cap;
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(negedge clk);
            if (bus.mul_start === 1'b1) begin
                a_cap = bus.mul_a;
                b_cap = bus.mul_b;
                start_cnt++;
                repeat (lat) @(posedge clk);
                #1;
                if (bus.state_out == 3'd4) begin
                    check("mul_a_hold", {28'b0, bus.mul_a}, {28'b0, a_cap});
                    check("mul_b_hold", {28'b0, bus.mul_b}, {28'b0, b_cap});
                end
                bus.mul_done    = 1'b1;
                bus.mul_product = {4'b0, a_cap} * {4'b0, b_cap};
                @(posedge clk); #1;
                bus.mul_done    = 1'b0;
                bus.mul_product = '0;
            end
        end
    end

    // Scoreboard monitor: pops whenever a new C element is presented
    initial begin
        logic       prev_c   = 1'b0;
        logic [1:0] prev_idx = '0;
        logic [17:0] exp_v;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_c = 1'b0;
            end else begin
                if (bus.complete && (!prev_c || bus.elem_index != prev_idx)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", {14'b0, bus.elem_index, bus.display_output}, 32'hFFFF_FFFF);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("result", {14'b0, bus.elem_index, bus.display_output}, {14'b0, exp_v});
                    end
                end
                prev_c   = bus.complete;
                prev_idx = bus.elem_index;
            end
        end
    end

    function automatic logic [31:0] all_outputs();
        return {bus.key_read, bus.mul_start, bus.mul_a, bus.mul_b, bus.display_output,
                bus.elem_index, bus.state_out, bus.complete};
    endfunction

    // Directed test sequence
    initial begin
        bus.read_input   = 1'b0;
        bus.keypad_input = '0;
        bus.equal_input  = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 0);
        rst = 1'b0;

        // Identity A, L=1
        lat = 1;
        press_digits(1, 0, 0, 1, 2, 3, 4, 5);
        check("state_wait_eq", {29'b0, bus.state_out}, 2);
        check("display_last_digit", {16'b0, bus.display_output}, 5);
        exp_q.push_back({2'd0, 16'd2});
        press(4'd15, 1);
        wait_complete(16);
        show_next(2'd1, 9'd3);
        show_next(2'd2, 9'd4);
        show_next(2'd3, 9'd5);

        // Maximum values, started by a digit in SHOW
        press(4'd9, 0);
        check("new_problem_complete", {31'b0, bus.complete}, 0);
        check("new_problem_state", {29'b0, bus.state_out}, 0);
        press(9, 0); press(9, 0); press(9, 0);
        press(9, 0); press(9, 0); press(9, 0); press(9, 0);
        start_cnt = 0;
        exp_q.push_back({2'd0, 16'h00A2});
        press(4'd15, 1);
        wait_complete(16);
        check("mul_start_count", start_cnt, 8);
        show_next(2'd1, 9'd162);
        show_next(2'd2, 9'd162);
        show_next(2'd3, 9'd162);

        // Operators and "=" interleaved during entry are discarded
        press(4'd1, 0);
        press(4'd10, 0); press(4'd2, 0); press(4'd0, 1); press(4'd3, 0);
        press(4'd11, 0); press(4'd4, 0);
        check("state_load_b", {29'b0, bus.state_out}, 1);
        press(4'd12, 0); press(4'd5, 0); press(4'd7, 1); press(4'd6, 0);
        press(4'd13, 0); press(4'd7, 0); press(4'd14, 0); press(4'd8, 0);
        press(4'd15, 0); press(4'd9, 0);
        check("wait_eq_discard", {29'b0, bus.state_out}, 2);
        exp_q.push_back({2'd0, 16'd19});
        press(4'd3, 1);
        wait_complete(16);
        show_next(2'd1, 9'd22);
        show_next(2'd2, 9'd43);
        show_next(2'd3, 9'd50);

        // L=3 with a stray mul_done while waiting for "="
        press(4'd2, 0);
        press(1, 0); press(0, 0); press(3, 0);
        press(1, 0); press(4, 0); press(2, 0); press(5, 0);
        @(posedge clk); #1;
        bus.mul_done    = 1'b1;
        bus.mul_product = 8'hFF;
        @(posedge clk); #1;
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        check("stray_done_ignored", {29'b0, bus.state_out}, 2);
        lat = 3;
        exp_q.push_back({2'd0, 16'd4});
        press(4'd15, 1);
        wait_complete(32);

        // SHOW navigation wraps 3 -> 0
        show_next(2'd1, 9'd13);
        show_next(2'd2, 9'd6);
        show_next(2'd3, 9'd15);
        show_next(2'd0, 9'd4);
        show_next(2'd1, 9'd13);

        // Digit 7 opens a new problem; the next digit lands in A01
        press(4'd7, 0);
        check("restart_complete", {31'b0, bus.complete}, 0);
        check("restart_state", {29'b0, bus.state_out}, 0);
        check("restart_display", {16'b0, bus.display_output}, 7);
        press(6, 0); press(1, 0); press(1, 0);
        press(1, 0); press(0, 0); press(0, 0); press(1, 0);
        lat = 1;
        exp_q.push_back({2'd0, 16'd7});
        press(4'd15, 1);
        wait_complete(16);
        show_next(2'd1, 9'd6);
        show_next(2'd2, 9'd1);
        show_next(2'd3, 9'd1);

        // Reset during the C01 multiplies, then a late mul_done
        lat = 4;
        press(4'd1, 0);
        press(2, 0); press(3, 0); press(4, 0);
        press(5, 0); press(6, 0); press(7, 0); press(8, 0);
        start_cnt = 0;
        press(4'd15, 1);
        begin
            int n = 0;
            while (start_cnt < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("reach_c01", start_cnt, 3);
        end
        @(posedge clk); #1;
        check("in_wait_mul", {29'b0, bus.state_out}, 4);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", all_outputs(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("late_done_ignored", all_outputs(), 0);

        // Fresh run after the abort
        lat = 1;
        press_digits(1, 2, 3, 4, 5, 6, 7, 8);
        exp_q.push_back({2'd0, 16'd19});
        press(4'd15, 1);
        wait_complete(16);
        show_next(2'd1, 9'd22);
        show_next(2'd2, 9'd43);
        show_next(2'd3, 9'd50);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Sequencer for the 2x2 matrix multiplier. It collects eight single-digit operands from the keypad controller over the read_input/key_read handshake. It then schedules one shared external multiplier to compute C = A x B, and presents the four results one at a time on the display bus. It sits between input_control and the display path, alongside gencon.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- read_input  in  1  key event pending from the keypad controller; held until key_read.
- keypad_input  in  4  key code; 0-9 are digits, 10-15 are operators.
- equal_input  in  1  qualifies read_input as the "=" key.
- key_read  out  1  one-cycle acknowledge of a key event.
- mul_start  out  1  one-cycle request to the shared multiplier.
- mul_a  out  4  multiplicand, held from mul_start until mul_done.
- mul_b  out  4  multiplier, held from mul_start until mul_done.
- mul_done  in  1  one-cycle completion pulse; latency ≥1 cycle after mul_start.
- mul_product  in  8  product, valid only while mul_done=1.
- display_output  out  16  selected C element, binary, zero-extended.
- elem_index  out  2  displayed element: 0=C00, 1=C01, 2=C10, 3=C11.
- state_out  out  3  FSM state code for FPGA debug.
- complete  out  1  high while results are valid.

## Operation
- FSM states and state_out codes: LOAD_A=0, LOAD_B=1, WAIT_EQ=2, ISSUE=3, WAIT_MUL=4, SHOW=5. Reset state is LOAD_A.
- Key acceptance:
  - A key event is any cycle with read_input=1 and key_read=0.
  - Every key event is acknowledged, in every state.
  - Whether it changes state depends on the state.
- LOAD_A / LOAD_B operand entry:
  - Each digit with equal_input=0 is stored to the next slot in row-major order: A00, A01, A10, A11, then B00, B01, B10, B11.
  - Operators and "=" are acknowledged and discarded.
  - The 4th A digit moves the FSM to LOAD_B. The 4th B digit moves it to WAIT_EQ.
- WAIT_EQ: "=" moves the FSM to ISSUE with i=j=k=0 and acc=0. Digits and operators are discarded.
- ISSUE:
  - Lasts 1 cycle.
  - Drives mul_start=1, mul_a=A[i][k], mul_b=B[k][j]; then moves to WAIT_MUL.
- WAIT_MUL:
  - On mul_done, acc += mul_product (9-bit accumulator).
  - If k=0: set k=1 and go to ISSUE.
  - Else: write C[i][j]=acc, clear acc, set k=0, and advance (i,j) in the order 00, 01, 10, 11.
  - After C11, go to SHOW with elem_index=0. Otherwise go to ISSUE.
- Multiply schedule: exactly 8 multiplies, in the order (C00: k0, k1), (C01: k0, k1), (C10: k0, k1), (C11: k0, k1).
- Arithmetic range: maximum product 81, maximum element 162. No overflow is possible.
- SHOW:
  - complete=1 and display_output={7'b0, C[elem_index]}.
  - "=" advances elem_index, wrapping 3→0.
  - A digit starts a new problem: clear all A, B and C registers, store the digit as A00, set complete=0, and go to LOAD_A with 1 entry counted.
  - Operators are discarded.
- mul_done outside WAIT_MUL is ignored.
- Key events during ISSUE/WAIT_MUL are acknowledged and discarded.
- Reset values:
  - key_read=0, mul_start=0, mul_a=0, mul_b=0.
  - display_output=0, elem_index=0, complete=0, state_out=0.
  - All operand, result and accumulator registers = 0.
- Reset asserted mid-operation aborts immediately and asynchronously. An in-flight multiply's later mul_done is ignored.
- Outside SHOW, display_output shows the most recently entered digit, zero-extended (0 after reset).

## Timing
- key_read is registered: high exactly 1 cycle, in the cycle after the key event is sampled.
- The operand store and any state change happen on the same edge that raises key_read.
- read_input is not sampled while key_read=1.
- Minimum key spacing is 2 cycles.
- Compute latency, with multiplier latency L (mul_done L cycles after mul_start):
  - Each multiply takes 1+L cycles.
  - From the "=" acknowledge edge to complete=1 is 8(1+L) cycles.
- complete rises on the edge after the final mul_done.
- elem_index and display_output update on the "=" acknowledge edge in SHOW.
- mul_a/mul_b are stable from the ISSUE cycle until the cycle mul_done is sampled.

## Test plan
- Identity: A=1,0,0,1, B=2,3,4,5, then "=" with L=1 → complete rises 16 cycles after the "=" acknowledge; C=2,3,4,5.
- Maximum values: A=9,9,9,9, B=9,9,9,9, then "=" → every element is 162 (display_output=16'h00A2); exactly 8 mul_start pulses.
- Discard: operators 10-15 and "=" interleaved during LOAD_A/LOAD_B → each gets key_read; operand slots and the result (A=1,2,3,4, B=5,6,7,8 → 19,22,43,50) are unchanged.
- Latency/spurious: L=3, plus a stray mul_done injected in WAIT_EQ → the stray pulse is ignored; results are correct; mul_a/mul_b are stable until mul_done.
- SHOW navigation: five "=" presses → elem_index goes 1,2,3,0,1. Then digit 7 → complete=0, state_out=0, next A00 slot filled as A01.
- Reset mid-compute: assert RST during WAIT_MUL of C01 → all outputs are 0 immediately. A late mul_done is ignored; a fresh run then computes correctly.
